// File: rtl/peak_finder_fsm_pkg.sv
// Shared defaults and state encoding for the histogram peak finder.
// Default widths track the histogram builder's bin, pixel and count widths.
package peak_finder_fsm_pkg;

    // Bin index width; each pixel histogram holds 2**PF_BIN_W bins.
    localparam int unsigned PF_BIN_W   = 8;
    // Pixel histograms stored in one RAM.
    localparam int unsigned PF_PIXELS  = 4;
    // Pixel index width, clog2(PF_PIXELS).
    localparam int unsigned PF_PIX_W   = 2;
    // Bin count width.
    localparam int unsigned PF_COUNT_W = 8;
    // RAM address = {pixel, bin}.
    localparam int unsigned PF_ADDR_W  = PF_PIX_W + PF_BIN_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        LAST = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } pfState_t;

endpackage

// File: rtl/peak_finder_fsm_max_tracker.sv
// Peak max tracker: running maximum and its bin index.
// loadFirst takes the sample unconditionally (first bin of a histogram);
// update takes it only when strictly greater, so ties keep the earliest bin.
// Written standalone so a second-peak search can reuse it.
module peak_finder_fsm_max_tracker
    import peak_finder_fsm_pkg::*;
#(
    parameter int unsigned BIN_W   = PF_BIN_W,
    parameter int unsigned COUNT_W = PF_COUNT_W
) (
    input  logic               clk,
    input  logic               res,
    input  logic               loadFirst,
    input  logic               update,
    input  logic [BIN_W-1:0]   binIn,
    input  logic [COUNT_W-1:0] countIn,
    output logic [BIN_W-1:0]   maxBin,
    output logic [COUNT_W-1:0] maxCount
);

    // Max/argmax registers: unconditional load on the first bin, strict-greater update after.
    always_ff @(posedge clk) begin
        if (!res) begin
            maxBin   <= '0;
            maxCount <= '0;
        end else if (loadFirst) begin
            maxBin   <= binIn;
            maxCount <= countIn;
        end else if (update && (countIn > maxCount)) begin
            maxBin   <= binIn;
            maxCount <= countIn;
        end
    end

endmodule

// File: rtl/peak_finder_fsm.sv
// Histogram peak finder.
// After the builder signals build-done, reads every bin of every pixel
// histogram through RAM port b, finds the highest-count bin per pixel and
// hands {pixel, bin, count} to the readout stage over valid/ready.
// Optional build macro PEAK_CLEAR_EN adds a write port (waddr/wEnable/wdata)
// that zeroes each bin one cycle after it is read, so the RAM is clean for
// the next acquisition frame.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for his_done
// SCAN  | issuing one bin read per cycle for the current pixel
// LAST  | no read issued; last bin's data arrives and is compared
// OUT   | result presented, waiting for peak_ready
// DONE  | one-cycle scan_done pulse, then back to IDLE
module peak_finder_fsm
    import peak_finder_fsm_pkg::*;
#(
    parameter int unsigned BIN_W   = PF_BIN_W,
    parameter int unsigned PIXELS  = PF_PIXELS,
    parameter int unsigned PIX_W   = PF_PIX_W,
    parameter int unsigned COUNT_W = PF_COUNT_W,
    parameter int unsigned ADDR_W  = PF_ADDR_W
) (
    input  logic               clk,
    input  logic               res,
    input  logic               his_done,
    output logic [ADDR_W-1:0]  raddr,
    output logic               rd_en,
    input  logic [COUNT_W-1:0] rdata,
    output logic               peak_valid,
    input  logic               peak_ready,
    output logic [PIX_W-1:0]   peak_pixel,
    output logic [BIN_W-1:0]   peak_bin,
    output logic [COUNT_W-1:0] peak_count,
    output logic               busy,
    output logic               scan_done
`ifdef PEAK_CLEAR_EN
    ,
    output logic [ADDR_W-1:0]  waddr,
    output logic               wEnable,
    output logic [COUNT_W-1:0] wdata
`endif
);

    pfState_t           state;
    logic [PIX_W-1:0]   pixel;
    logic [BIN_W-1:0]   bin;
    // rdPend/pendBin describe the datum arriving on rdata this cycle.
    logic               rdPend;
    logic [BIN_W-1:0]   pendBin;
    logic               firstBin;

    // Pixel and bin live in separate registers, so the bin wraps without
    // ever carrying into the pixel field of the address.
    assign raddr      = {pixel, bin};
    assign peak_pixel = pixel;
    assign firstBin   = rdPend && (pendBin == '0);

    // Sequencer: state, read issue, result handshake and status flags.
    always_ff @(posedge clk) begin
        if (!res) begin
            state      <= IDLE;
            pixel      <= '0;
            bin        <= '0;
            rd_en      <= 1'b0;
            peak_valid <= 1'b0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    scan_done <= 1'b0;
                    if (his_done) begin
                        state <= SCAN;
                        pixel <= '0;
                        bin   <= '0;
                        rd_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (&bin) begin
                        state <= LAST;
                        rd_en <= 1'b0;
                        bin   <= '0;
                    end else begin
                        rd_en <= 1'b1;
                        bin   <= bin + BIN_W'(1);
                    end
                end
                LAST: begin
                    state      <= OUT;
                    peak_valid <= 1'b1;
                end
                OUT: begin
                    if (peak_valid && peak_ready) begin
                        peak_valid <= 1'b0;
                        if (pixel == PIX_W'(PIXELS - 1)) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            scan_done <= 1'b1;
                        end else begin
                            state <= SCAN;
                            pixel <= pixel + PIX_W'(1);
                            bin   <= '0;
                            rd_en <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    scan_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    rd_en      <= 1'b0;
                    peak_valid <= 1'b0;
                    busy       <= 1'b0;
                    scan_done  <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle read-latency pipeline tagging the datum that arrives next cycle.
    always_ff @(posedge clk) begin
        if (!res) begin
            rdPend  <= 1'b0;
            pendBin <= '0;
        end else begin
            rdPend  <= rd_en;
            pendBin <= bin;
        end
    end

    peak_finder_fsm_max_tracker #(
        .BIN_W   (BIN_W),
        .COUNT_W (COUNT_W)
    ) uTracker (
        .clk       (clk),
        .res       (res),
        .loadFirst (firstBin),
        .update    (rdPend),
        .binIn     (pendBin),
        .countIn   (rdata),
        .maxBin    (peak_bin),
        .maxCount  (peak_count)
    );

`ifdef PEAK_CLEAR_EN
    assign wdata = '0;

    // Clear-behind: write zero to each bin as its read data comes back.
    always_ff @(posedge clk) begin
        if (!res) begin
            waddr   <= '0;
            wEnable <= 1'b0;
        end else begin
            waddr   <= raddr;
            wEnable <= rd_en;
        end
    end
`endif

endmodule

// File: tb/tb_peak_finder_fsm.sv
// Directed bench for peak_finder_fsm with a small geometry (8 bins, 2 pixels)
// and a 1-cycle-latency RAM model. With PEAK_CLEAR_EN defined the bench also
// checks the clear-behind write port.
module tb_peak_finder_fsm;

    localparam int BW = 3;
    localparam int NP = 2;
    localparam int PW = 1;
    localparam int CW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          res;
    logic          his_done;
    logic [AW-1:0] raddr;
    logic          rd_en;
    logic [CW-1:0] rdata;
    logic          peak_valid;
    logic          peak_ready;
    logic [PW-1:0] peak_pixel;
    logic [BW-1:0] peak_bin;
    logic [CW-1:0] peak_count;
    logic          busy;
    logic          scan_done;
`ifdef PEAK_CLEAR_EN
    logic [AW-1:0] waddr;
    logic          wEnable;
    logic [CW-1:0] wdata;
    logic [11:0]   wLog[$];
    logic          monOn = 1'b0;
`endif

    logic [CW-1:0] mem [16];
    logic          ldEn;
    logic [AW-1:0] ldAddr;
    logic [CW-1:0] ldData;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] cnt;
        logic [2:0]  bin;
        logic [7:0]  count;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    peak_finder_fsm #(
        .BIN_W(BW), .PIXELS(NP), .PIX_W(PW), .COUNT_W(CW), .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .res        (res),
        .his_done   (his_done),
        .raddr      (raddr),
        .rd_en      (rd_en),
        .rdata      (rdata),
        .peak_valid (peak_valid),
        .peak_ready (peak_ready),
        .peak_pixel (peak_pixel),
        .peak_bin   (peak_bin),
        .peak_count (peak_count),
        .busy       (busy),
        .scan_done  (scan_done)
`ifdef PEAK_CLEAR_EN
        ,
        .waddr      (waddr),
        .wEnable    (wEnable),
        .wdata      (wdata)
`endif
    );

    // RAM model: registered read, loader port, optional clear-behind writes.
    always @(posedge clk) begin
        if (rd_en) rdata <= mem[raddr];
        if (ldEn) mem[ldAddr] <= ldData;
`ifdef PEAK_CLEAR_EN
        if (wEnable) mem[waddr] <= wdata;
`endif
    end

`ifdef PEAK_CLEAR_EN
    // Log every clear write while monitoring is enabled.
    always @(negedge clk) begin
        if (monOn && wEnable) wLog.push_back({wdata, waddr});
    end
`endif

    function automatic vec_t mk(input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2, input logic [7:0] c3,
                                input logic [7:0] c4, input logic [7:0] c5,
                                input logic [7:0] c6, input logic [7:0] c7,
                                input logic [2:0] b, input logic [7:0] c);
        vec_t v;
        v.cnt   = {c7, c6, c5, c4, c3, c2, c1, c0};
        v.bin   = b;
        v.count = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic loadMem(input int pix, input int vi);
        for (int b = 0; b < 8; b++) begin
            ldEn   = 1'b1;
            ldAddr = AW'(pix * 8 + b);
            ldData = vecs[vi].cnt[b*8 +: 8];
            @(negedge clk);
        end
        ldEn = 1'b0;
    endtask

    task automatic waitValid(input int startN, output int n, output int reads);
        n = startN;
        reads = 0;
        if (n == 0) begin
            @(negedge clk);
            n = 1;
        end
        while (1) begin
            if (rd_en) reads++;
            if (peak_valid || n >= 40) break;
            @(negedge clk);
            n++;
        end
    endtask

    // Collect both pixel results; startN=1 means the first SCAN cycle is already being sampled.
    task automatic collectScan(input int startN, input int v0, input int v1, input int stall);
        int n, reads, nextStart, vi;
        logic [17:0] snap;
        nextStart = startN;
        for (int p = 0; p < NP; p++) begin
            vi = (p == 0) ? v0 : v1;
            waitValid(nextStart, n, reads);
            check("latency", 64'(n), 64'(10));
            check("reads", 64'(reads), 64'(8));
            check("peak_pixel", 64'(peak_pixel), 64'(p));
            check("peak_bin", 64'(peak_bin), 64'(vecs[vi].bin));
            check("peak_count", 64'(peak_count), 64'(vecs[vi].count));
            nextStart = 0;
            if (p == 0 && stall > 0) begin
                snap = {peak_valid, 1'b0, peak_pixel, peak_bin, peak_count, 4'h0};
                for (int k = 2; k <= stall + 1; k++) begin
                    @(negedge clk);
                    check("stall_hold", {peak_valid, rd_en, peak_pixel, peak_bin, peak_count, 4'h0}, snap);
                    if (k == stall + 1) peak_ready = 1'b1;
                end
                @(negedge clk);
                check("resume", {peak_valid, rd_en, raddr}, {1'b0, 1'b1, 4'd8});
                nextStart = 1;
            end
        end
        @(negedge clk);
        check("done_pulse", {scan_done, busy, peak_valid}, 3'b100);
        @(negedge clk);
        check("done_clear", {scan_done, busy, peak_valid}, 3'b000);
    endtask

    task automatic doScan(input int v0, input int v1, input int stall, input bit holdHis);
        loadMem(0, v0);
        loadMem(1, v1);
        peak_ready = (stall == 0);
        his_done = 1'b1;
        @(negedge clk);
        if (!holdHis) his_done = 1'b0;
        check("busy_rise", {busy, rd_en, raddr}, {1'b1, 1'b1, 4'd0});
        collectScan(1, v0, v1, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        vecs[0] = mk(1, 5, 3, 9, 2, 0, 4, 1,         3'd3, 8'd9);
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0,         3'd0, 8'd0);
        vecs[2] = mk(0, 7, 2, 7, 7, 0, 0, 0,         3'd1, 8'd7);
        vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 255,       3'd7, 8'd255);
        vecs[4] = mk(255, 255, 255, 255, 255, 255, 255, 255, 3'd0, 8'd255);
        vecs[5] = mk(3, 200, 10, 201, 201, 0, 0, 200, 3'd3, 8'd201);
        vecs[6] = mk(128, 127, 129, 0, 0, 0, 0, 1,   3'd2, 8'd129);
        vecs[7] = mk(9, 0, 0, 0, 0, 0, 0, 9,         3'd0, 8'd9);

        res = 1'b0;
        his_done = 1'b0;
        peak_ready = 1'b1;
        ldEn = 1'b0;
        ldAddr = '0;
        ldData = '0;
        repeat (3) @(negedge clk);
        check("reset_state",
              {raddr, rd_en, peak_valid, peak_pixel, peak_bin, peak_count, busy, scan_done}, 64'd0);
        res = 1'b1;
        @(negedge clk);

        // Table-driven scans: {pixel0 vector, pixel1 vector, stall cycles}.
        doScan(0, 1, 0, 1'b0);
        doScan(2, 3, 0, 1'b0);
        doScan(4, 5, 5, 1'b0);

        // his_done held high: ignored while busy, restarts one cycle after DONE.
        doScan(6, 7, 0, 1'b1);
        @(negedge clk);
        check("hold_restart", {busy, rd_en, raddr, peak_pixel}, {1'b1, 1'b1, 4'd0, 1'b0});
        his_done = 1'b0;
`ifdef PEAK_CLEAR_EN
        collectScan(1, 1, 1, 0);
`else
        collectScan(1, 6, 7, 0);
`endif

        // Reset in the middle of pixel 1, bin 4.
        loadMem(0, 0);
        loadMem(1, 5);
        peak_ready = 1'b1;
        his_done = 1'b1;
        @(negedge clk);
        his_done = 1'b0;
        begin
            int n, reads;
            waitValid(1, n, reads);
            check("mid_pix0_bin", 64'(peak_bin), 64'(3));
        end
        cnt = 0;
        while (!(rd_en && raddr == 4'd12) && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_bin4", {rd_en, raddr}, {1'b1, 4'd12});
        res = 1'b0;
        @(negedge clk);
        check("midreset_zero",
              {raddr, rd_en, peak_valid, peak_pixel, peak_bin, peak_count, busy, scan_done}, 64'd0);
        res = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (scan_done || peak_valid || busy || rd_en) cnt++;
        end
        check("no_activity", 64'(cnt), 64'd0);
        doScan(5, 0, 0, 1'b0);

`ifdef PEAK_CLEAR_EN
        wLog.delete();
        monOn = 1'b1;
        doScan(2, 3, 0, 1'b0);
        monOn = 1'b0;
        check("clr_count", 64'(wLog.size()), 64'd16);
        for (int i = 0; i < 16 && i < wLog.size(); i++) begin
            check("clr_write", 64'(wLog[i]), {52'd0, 8'd0, 4'(i)});
        end
        peak_ready = 1'b1;
        his_done = 1'b1;
        @(negedge clk);
        his_done = 1'b0;
        collectScan(1, 1, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
